// File: rtl/rast_params.sv
// Shared rasterizer front-end definitions: geometry sizes, triangle/color
// container types and the issue-slot state encoding used by tri_arb.
package rast_params;

  localparam int SIGFIG = 24;  // bits per coordinate / color channel
  localparam int RADIX  = 10;  // fraction bits, carried through untouched
  localparam int VERTS  = 3;   // vertices per triangle
  localparam int AXIS   = 3;   // axes per vertex
  localparam int COLORS = 3;   // color channels
  localparam int REQS   = 4;   // triangle sources sharing the rasterizer

  typedef logic signed   [SIGFIG-1:0] tri_t   [VERTS-1:0][AXIS-1:0];
  typedef logic unsigned [SIGFIG-1:0] color_t [COLORS-1:0];

  // Output slot occupancy: EMPTY = nothing presented to rast, FULL = held.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted valid bit scanning upward from
// ptr, wrapping modulo REQS. Purely combinational.
module rr_pick #(
  parameter int REQS  = 4,
  parameter int IDX_W = 2
) (
  input  logic [REQS-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [REQS-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Two copies of the valid vector rotated so bit 0 is the requester at ptr;
  // the first set bit k then names requester (ptr + k) mod REQS.
  logic [2*REQS-1:0] rotated;
  int                pos;

  // Priority scan of the rotated vector and one-hot encoding of the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    rotated = {valid, valid} >> ptr;
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    for (int k = 0; k < REQS; k++) begin
      if (!any && rotated[k]) begin
        any = 1'b1;
        pos = int'(ptr) + k;
        if (pos >= REQS) begin
          pos = pos - REQS;
        end
        idx = IDX_W'(pos);
      end
    end
    if (any) begin
      grant = REQS'(1) << idx;
    end
  end

endmodule

// File: rtl/tri_arb.sv
// tri_arb: round-robin triangle arbiter and single-entry issue slot in front
// of rast. Up to REQS sources offer triangles; one is granted whenever the
// slot is empty or being accepted this cycle, and the slot holds it until
// rast takes it (validTri_R10H && halt_RnnnnL).
//
// Build option: define TRI_ARB_STATS_EN to implement the per-requester grant
// counters and the stall counter. Without it both ports read 0 and no
// counter registers exist; arbitration is identical either way.
module tri_arb #(
  parameter int SIGFIG = rast_params::SIGFIG,
  parameter int RADIX  = rast_params::RADIX,
  parameter int VERTS  = rast_params::VERTS,
  parameter int AXIS   = rast_params::AXIS,
  parameter int COLORS = rast_params::COLORS,
  parameter int REQS   = rast_params::REQS,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQS-1:0]          req_valid,
  output logic [REQS-1:0]          req_ready,
  input  logic signed [SIGFIG-1:0] req_tri   [REQS-1:0][VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] req_color [REQS-1:0][COLORS-1:0],
  input  logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R10S   [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R10U [COLORS-1:0],
  output logic                     validTri_R10H,
  output logic [$clog2(REQS)-1:0]  owner,
  output logic                     idle,
  output logic [CNT_W-1:0]         grant_cnt [REQS-1:0],
  output logic [CNT_W-1:0]         stall_cnt
);

  import rast_params::*;

  localparam int IDX_W = $clog2(REQS);

  // Elaboration-time guards on the configuration.
  if (REQS < 2 || REQS > 8) begin : g_bad_reqs
    $error("tri_arb: REQS must be in 2..8");
  end
  if (RADIX >= SIGFIG) begin : g_bad_radix
    $error("tri_arb: RADIX must be smaller than SIGFIG");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;

  logic [REQS-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic accept;  // rast takes the presented triangle this cycle
  logic load;    // slot can take a new triangle at the next edge
  logic take;    // a requester is actually granted this cycle

  assign validTri_R10H = (state_q == FULL);
  assign accept        = validTri_R10H && halt_RnnnnL;
  assign load          = !validTri_R10H || accept;
  assign take          = load && pick_any && !rst;

  // Ready is the picker's one-hot gated by slot availability; silent in reset.
  assign req_ready = take ? pick_grant : '0;

  assign idle = !validTri_R10H && halt_RnnnnL && !(|req_valid);

  rr_pick #(
    .REQS  (REQS),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Slot occupancy next-state: fill on a grant, drain on an ungranted accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (pick_any) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = pick_any ? FULL : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Slot occupancy register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot payload, owner and round-robin pointer; loaded only on a grant so a
  // stalled or emptied slot keeps its last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload is a handful of flops rather than a RAM, so it is
      // cleared in reset to give rast a defined bus from the first cycle.
      for (int v = 0; v < VERTS; v++) begin
        for (int a = 0; a < AXIS; a++) begin
          tri_R10S[v][a] <= '0;
        end
      end
      for (int c = 0; c < COLORS; c++) begin
        color_R10U[c] <= '0;
      end
      owner <= '0;
      ptr_q <= '0;
    end else if (take) begin
      for (int v = 0; v < VERTS; v++) begin
        for (int a = 0; a < AXIS; a++) begin
          tri_R10S[v][a] <= req_tri[pick_idx][v][a];
        end
      end
      for (int c = 0; c < COLORS; c++) begin
        color_R10U[c] <= req_color[pick_idx][c];
      end
      owner <= pick_idx;
      if (pick_idx == IDX_W'(REQS - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= pick_idx + 1'b1;
      end
    end
  end

`ifdef TRI_ARB_STATS_EN
  // Saturating statistics: accepted triangles per owner and stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQS; i++) begin
        grant_cnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      if (accept && (grant_cnt[owner] != '1)) begin
        grant_cnt[owner] <= grant_cnt[owner] + 1'b1;
      end
      if (validTri_R10H && !halt_RnnnnL && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  // Statistics not built: ports kept for the integrating top, tied to zero.
  always_comb begin
    for (int i = 0; i < REQS; i++) begin
      grant_cnt[i] = '0;
    end
    stall_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_tri_arb.sv
// Self-checking bench for tri_arb: a transaction-level model of the issue
// slot is compared against the DUT every cycle, and directed scenarios pin
// hand-computed owners, ready patterns, data words and counter values.
module tb_tri_arb;

  import rast_params::*;

  localparam int CNT_W = 32;
  localparam int IDX_W = $clog2(REQS);
`ifdef TRI_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [REQS-1:0]          req_valid;
  logic [REQS-1:0]          req_ready;
  logic signed [SIGFIG-1:0] req_tri   [REQS-1:0][VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] req_color [REQS-1:0][COLORS-1:0];
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R10S   [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_R10U [COLORS-1:0];
  logic                     validTri_R10H;
  logic [IDX_W-1:0]         owner;
  logic                     idle;
  logic [CNT_W-1:0]         grant_cnt [REQS-1:0];
  logic [CNT_W-1:0]         stall_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tri_arb #(
    .SIGFIG (SIGFIG),
    .RADIX  (RADIX),
    .VERTS  (VERTS),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .REQS   (REQS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tri       (req_tri),
    .req_color     (req_color),
    .halt_RnnnnL   (halt_RnnnnL),
    .tri_R10S      (tri_R10S),
    .color_R10U    (color_R10U),
    .validTri_R10H (validTri_R10H),
    .owner         (owner),
    .idle          (idle),
    .grant_cnt     (grant_cnt),
    .stall_cnt     (stall_cnt)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VERTS*AXIS*SIGFIG-1:0] pack_tri(input tri_t t);
    logic [VERTS*AXIS*SIGFIG-1:0] r;
    r = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        r[(v*AXIS+a)*SIGFIG +: SIGFIG] = t[v][a];
    return r;
  endfunction

  function automatic logic [COLORS*SIGFIG-1:0] pack_color(input color_t c);
    logic [COLORS*SIGFIG-1:0] r;
    r = '0;
    for (int i = 0; i < COLORS; i++) r[i*SIGFIG +: SIGFIG] = c[i];
    return r;
  endfunction

  // First valid requester at or after p, wrapping; -1 when none is valid.
  function automatic int pick(input logic [REQS-1:0] v, input int p);
    int unsigned vm = v;
    for (int k = 0; k < REQS; k++) begin
      int c = (p + k) % REQS;
      if (((vm >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic int unsigned exp_cnt(input int unsigned n);
    return STATS ? n : 0;
  endfunction

  // ---------------- transaction-level model ----------------
  bit          m_valid;
  int          m_owner;
  int          m_ptr;
  tri_t        m_tri;
  color_t      m_color;
  int unsigned m_gcnt [REQS];
  int unsigned m_scnt;
  int          m_sel;
  logic [REQS-1:0] exp_ready;

  always_comb m_sel = pick(req_valid, m_ptr);

  always_comb begin
    exp_ready = '0;
    if (!rst && (!m_valid || halt_RnnnnL) && m_sel >= 0) exp_ready = REQS'(1) << m_sel;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_scnt  <= 0;
      for (int i = 0; i < REQS; i++) m_gcnt[i] <= 0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) m_tri[v][a] <= '0;
      for (int c = 0; c < COLORS; c++) m_color[c] <= '0;
    end else begin
      for (int i = 0; i < REQS; i++)
        if (m_valid && halt_RnnnnL && i == m_owner && m_gcnt[i] != 32'hFFFF_FFFF)
          m_gcnt[i] <= m_gcnt[i] + 1;
      if (m_valid && !halt_RnnnnL && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
      if (!m_valid || halt_RnnnnL) begin
        if (m_sel >= 0) begin
          m_valid <= 1'b1;
          m_owner <= m_sel;
          m_ptr   <= (m_sel + 1) % REQS;
          for (int i = 0; i < REQS; i++) begin
            if (i == m_sel) begin
              for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++) m_tri[v][a] <= req_tri[i][v][a];
              for (int c = 0; c < COLORS; c++) m_color[c] <= req_color[i][c];
            end
          end
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", req_ready, exp_ready);
      check("cyc_valid", validTri_R10H, m_valid);
      check("cyc_owner", owner, m_owner);
      check("cyc_tri", pack_tri(tri_R10S), pack_tri(m_tri));
      check("cyc_color", pack_color(color_R10U), pack_color(m_color));
      check("cyc_idle", idle, !m_valid && halt_RnnnnL && !(|req_valid));
      for (int i = 0; i < REQS; i++) check("cyc_grant_cnt", grant_cnt[i], exp_cnt(m_gcnt[i]));
      check("cyc_stall_cnt", stall_cnt, exp_cnt(m_scnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    halt_RnnnnL = 1'b1;
    req_valid   = '0;
    step();
    rst = 1'b0;
  endtask

  // Requester i, vertex v, axis a carries +/-(1000i + 100v + 10a + g);
  // color channel c carries 4096i + 256c + g.
  task automatic set_data(input int g);
    int val;
    for (int i = 0; i < REQS; i++) begin
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) begin
          val = i*1000 + v*100 + a*10 + g;
          if (i % 2 == 1) val = -val;
          req_tri[i][v][a] = val[SIGFIG-1:0];
        end
      for (int c = 0; c < COLORS; c++) begin
        val = i*4096 + c*256 + g;
        req_color[i][c] = val[SIGFIG-1:0];
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    halt_RnnnnL = 1'b1;
    req_valid   = '0;
    set_data(0);
    step();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", validTri_R10H, 1'b0);
    check("rst_owner", owner, 0);
    check("rst_idle", idle, 1'b1);

    // Single requester 2.
    req_valid = 4'b0100;
    #1 check("t1_ready", req_ready, 4'b0100);
    step();
    check("t1_valid", validTri_R10H, 1'b1);
    check("t1_owner", owner, 2);
    check("t1_tri12", tri_R10S[1][2], 24'd2120);
    check("t1_color1", color_R10U[1], 24'd8448);
    req_valid = '0;
    #1 check("t1_not_idle", idle, 1'b0);
    step();
    check("t1_grant_cnt2", grant_cnt[2], exp_cnt(1));
    check("t1_idle", idle, 1'b1);

    // Round robin, all valid, 8 cycles.
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_valid", validTri_R10H, 1'b1);
      check("t2_owner", owner, k % 4);
    end
    req_valid = '0;
    step();
    check("t2_drained", validTri_R10H, 1'b0);
    for (int i = 0; i < REQS; i++) check("t2_grant_cnt", grant_cnt[i], exp_cnt(2));

    // Stall for 5 cycles with a new triangle waiting.
    do_reset();
    set_data(5);
    req_valid = 4'b0001;
    step();
    halt_RnnnnL = 1'b0;
    set_data(6);
    for (int k = 0; k < 5; k++) begin
      #1 check("t3_ready_stalled", req_ready, 4'b0000);
      step();
      check("t3_valid", validTri_R10H, 1'b1);
      check("t3_tri00_frozen", tri_R10S[0][0], 24'd5);
    end
    check("t3_stall_cnt", stall_cnt, exp_cnt(5));
    halt_RnnnnL = 1'b1;
    #1 check("t3_ready_release", req_ready, 4'b0001);
    step();
    check("t3_tri00_next", tri_R10S[0][0], 24'd6);
    check("t3_grant_cnt0", grant_cnt[0], exp_cnt(1));
    req_valid = '0;
    step();
    check("t3_empty", validTri_R10H, 1'b0);
    check("t3_grant_cnt0_b", grant_cnt[0], exp_cnt(2));

    // Pointer order: requesters 1 and 3 with ptr at 2, then 0 joins.
    do_reset();
    set_data(9);
    req_valid = 4'b0010;
    step();
    check("t4_owner1", owner, 1);
    req_valid = 4'b1010;
    #1 check("t4_ready3", req_ready, 4'b1000);
    step();
    check("t4_owner3", owner, 3);
    req_valid = 4'b0011;
    #1 check("t4_ready0", req_ready, 4'b0001);
    step();
    check("t4_owner0", owner, 0);
    req_valid = 4'b0010;
    #1 check("t4_ready1", req_ready, 4'b0010);
    step();
    check("t4_owner1b", owner, 1);
    req_valid = '0;
    step();

    // Reset while full and halted.
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid   = '0;
    halt_RnnnnL = 1'b0;
    step();
    check("t5_stall_cnt", stall_cnt, exp_cnt(1));
    rst         = 1'b1;
    req_valid   = 4'b0001;
    halt_RnnnnL = 1'b1;
    #1 check("t5_ready_in_reset", req_ready, 4'b0000);
    step();
    rst = 1'b0;
    check("t5_valid", validTri_R10H, 1'b0);
    check("t5_stall_zero", stall_cnt, 0);
    check("t5_grant2_zero", grant_cnt[2], 0);
    req_valid = 4'hF;
    #1 check("t5_ptr0", req_ready, 4'b0001);
    step();
    check("t5_owner0", owner, 0);
    req_valid = '0;
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
